// File: rtl/sample_frame_reader.sv
// -----------------------------------------------------------------------------
// sample_frame_reader
//
// Purpose
//   Streams one frame of samples out of a synchronous sample RAM. A START
//   pulse (while idle) captures LENGTH and the block reads addresses
//   0 .. LENGTH-1 in order. Each sample is presented on a valid/ready output
//   stream. A 2-entry skid buffer absorbs RAM data that is already in flight
//   when the downstream stalls, so no sample is lost or duplicated.
//
// Configuration
//   SAMPLE_FRAME_READER_LOOP_EN : when defined, the frame repeats endlessly
//   (address LENGTH-1 is followed by address 0 with no gap). DONE pulses at
//   every frame boundary, BUSY stays high, and only RESET stops playback.
//   When undefined, each frame plays once and the block returns to idle.
//
// Parameters
//   DATA_W : sample width in bits
//   ADDR_W : sample RAM address width
//
// Ports
//   CLK        in   sole clock, rising edge
//   RESET      in   synchronous active-high reset (wins over START)
//   START      in   one-cycle frame start request, ignored while BUSY
//   LENGTH     in   frame sample count, captured when START is accepted
//   RAM_RD_EN  out  RAM read strobe
//   RAM_ADDR   out  RAM read address (0 when RAM_RD_EN is low)
//   RAM_DATA   in   RAM read data, valid exactly one cycle after RAM_RD_EN
//   OUT_DATA   out  streamed sample (0 when OUT_VALID is low)
//   OUT_VALID  out  OUT_DATA holds a sample
//   OUT_READY  in   downstream accepts the sample
//   BUSY       out  frame in progress
//   DONE       out  one-cycle pulse after the last sample of a frame is taken
//   fsm_state  out  current controller state (IDLE=0, READ=1, DRAIN=2)
//
// Output handshake
//   A sample transfers on every rising edge where OUT_VALID && OUT_READY.
//   Once OUT_VALID is high, OUT_VALID and OUT_DATA hold unchanged until that
//   transfer happens; OUT_VALID never depends on OUT_READY.
// -----------------------------------------------------------------------------
module sample_frame_reader #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [ADDR_W-1:0] LENGTH,
    output logic              RAM_RD_EN,
    output logic [ADDR_W-1:0] RAM_ADDR,
    input  logic [DATA_W-1:0] RAM_DATA,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              BUSY,
    output logic              DONE,
    output logic [1:0]        fsm_state
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state;

    // Frame bookkeeping
    logic [ADDR_W-1:0] len_last;   // LENGTH-1 of the running frame
    logic [ADDR_W-1:0] next_addr;  // next address to be read
    logic [ADDR_W-1:0] out_idx;    // index within the frame of the sample on OUT

    // inflight: a read was issued last cycle, so RAM_DATA carries a sample now
    logic              inflight;

    // 2-entry skid buffer, always older than the in-flight sample
    logic [DATA_W-1:0] skid [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    logic              xfer;
    logic              push;
    logic              pop;
    logic              frame_end;
    logic              space_ok;
    logic [1:0]        next_count;

    assign fsm_state = state;

    // -------------------------------------------------------------------------
    // Output selection and buffer control
    // -------------------------------------------------------------------------
    always_comb begin
        OUT_VALID = (count != 2'd0) || inflight;

        // Buffered samples come first; with an empty buffer the arriving RAM
        // word is passed straight through, which gives the 2-cycle
        // START-to-OUT_VALID latency.
        if (count != 2'd0) begin
            OUT_DATA = skid[rd_ptr];
        end else if (inflight) begin
            OUT_DATA = RAM_DATA;
        end else begin
            OUT_DATA = '0;
        end

        xfer = OUT_VALID && OUT_READY;

        // The arriving word bypasses the buffer only when the buffer is empty
        // and the word is consumed in this very cycle.
        push = inflight && !(xfer && (count == 2'd0));
        pop  = xfer && (count != 2'd0);

        next_count = count + {1'b0, push} - {1'b0, pop};

        // A new read may be issued for next cycle only if, counting the
        // read issued this cycle (still in the RAM pipeline), fewer than two
        // samples would be outstanding. This keeps buffered + in-flight <= 2.
        space_ok = ({1'b0, next_count} + {2'b00, RAM_RD_EN}) < 3'd2;

        frame_end = xfer && (out_idx == len_last);
    end

`ifndef SAMPLE_FRAME_READER_LOOP_EN
    // The read of the final address is on the RAM port this cycle.
    logic last_issue;
    assign last_issue = RAM_RD_EN && (RAM_ADDR == len_last);
`endif

    // -------------------------------------------------------------------------
    // Controller, read issue and skid buffer state
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            RAM_RD_EN <= 1'b0;
            RAM_ADDR  <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            len_last  <= '0;
            next_addr <= '0;
            out_idx   <= '0;
            inflight  <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            skid[0]   <= '0;
            skid[1]   <= '0;
        end else begin
            DONE     <= 1'b0;
            inflight <= RAM_RD_EN;
            count    <= next_count;

            if (push) begin
                skid[wr_ptr] <= RAM_DATA;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (xfer) begin
                out_idx <= frame_end ? '0 : out_idx + ADDR_ONE;
            end

            case (state)
                S_IDLE: begin
                    RAM_RD_EN <= 1'b0;
                    RAM_ADDR  <= '0;
                    if (START) begin
                        if (LENGTH == '0) begin
                            // Empty frame: nothing to read, just acknowledge.
                            DONE <= 1'b1;
                        end else begin
                            state     <= S_READ;
                            BUSY      <= 1'b1;
                            len_last  <= LENGTH - ADDR_ONE;
                            out_idx   <= '0;
                            RAM_RD_EN <= 1'b1;
                            RAM_ADDR  <= '0;
`ifdef SAMPLE_FRAME_READER_LOOP_EN
                            // A one-sample loop re-reads address 0 forever.
                            next_addr <= (LENGTH == ADDR_ONE) ? '0 : ADDR_ONE;
`else
                            next_addr <= ADDR_ONE;
`endif
                        end
                    end
                end

                S_READ: begin
`ifdef SAMPLE_FRAME_READER_LOOP_EN
                    if (space_ok) begin
                        RAM_RD_EN <= 1'b1;
                        RAM_ADDR  <= next_addr;
                        next_addr <= (next_addr == len_last) ? '0
                                                             : next_addr + ADDR_ONE;
                    end else begin
                        RAM_RD_EN <= 1'b0;
                        RAM_ADDR  <= '0;
                    end
                    if (frame_end) begin
                        DONE <= 1'b1;
                    end
`else
                    if (last_issue) begin
                        // Every address has been requested; only delivery
                        // of the outstanding samples remains.
                        state     <= S_DRAIN;
                        RAM_RD_EN <= 1'b0;
                        RAM_ADDR  <= '0;
                    end else if (space_ok) begin
                        // next_addr never exceeds LENGTH-1 here, so the
                        // counter cannot wrap even for the largest frame.
                        RAM_RD_EN <= 1'b1;
                        RAM_ADDR  <= next_addr;
                        next_addr <= next_addr + ADDR_ONE;
                    end else begin
                        RAM_RD_EN <= 1'b0;
                        RAM_ADDR  <= '0;
                    end
`endif
                end

                S_DRAIN: begin
                    RAM_RD_EN <= 1'b0;
                    RAM_ADDR  <= '0;
                    if (frame_end) begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    RAM_RD_EN <= 1'b0;
                    RAM_ADDR  <= '0;
                    BUSY      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_frame_reader.sv
// -----------------------------------------------------------------------------
// tb_sample_frame_reader
//
// Self-checking bench for sample_frame_reader. A behavioural synchronous RAM
// holds RAM[i] = i + 100. A per-cycle vector table covers the basic frame,
// an ignored second START, LENGTH=0 and a stalled two-sample frame; hand
// sequences cover a 1,0,0 OUT_READY pattern, the largest frame, reset in the
// middle of a frame and (with SAMPLE_FRAME_READER_LOOP_EN) looped playback.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sample_frame_reader;

    localparam int DATA_W = 12;
    localparam int ADDR_W = 10;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] length;
    logic              rd_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic [1:0]        fsm_state;

    always #5 clk = ~clk;

    sample_frame_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .CLK       (clk),
        .RESET     (reset),
        .START     (start),
        .LENGTH    (length),
        .RAM_RD_EN (rd_en),
        .RAM_ADDR  (ram_addr),
        .RAM_DATA  (ram_data),
        .OUT_DATA  (out_data),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .BUSY      (busy),
        .DONE      (done),
        .fsm_state (fsm_state)
    );

    // Synchronous sample RAM: data appears the cycle after the read strobe.
    logic [DATA_W-1:0] ram [1<<ADDR_W];
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = DATA_W'(i + 100);
    end
    always @(posedge clk) begin
        if (rd_en) ram_data <= ram[ram_addr];
    end

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic next_cycle(input logic s, input logic [ADDR_W-1:0] l, input logic r);
        @(negedge clk);
        start     = s;
        length    = l;
        out_ready = r;
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_en"},     32'(rd_en),     32'd0);
        check({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_state"},     32'(fsm_state), 32'd0);
    endtask

    // Runs one complete frame (default build). mode 0: OUT_READY always 1,
    // mode 1: OUT_READY repeats 1,0,0.
    task automatic run_frame(input int len, input int mode, input string tag);
        int  issued = 0;
        int  xfers  = 0;
        int  k      = 0;
        int  last_xfer_k = -10;
        bit  got_done = 1'b0;
        bit  stalled  = 1'b0;
        logic [DATA_W-1:0] held = '0;
        exp_q.delete();
        for (int i = 0; i < len; i++) exp_q.push_back(DATA_W'(i + 100));
        while (!got_done && k < len * 3 + 20) begin
            next_cycle(k == 0, (k == 0) ? ADDR_W'(len) : '0,
                       (mode == 0) ? 1'b1 : ((k % 3) == 0));
            if (stalled) begin
                check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_data"},  32'(out_data),  32'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check({tag, "_sample_count"}, 32'(xfers + 1), 32'(len));
                else check({tag, "_data"}, 32'(out_data), 32'(exp_q.pop_front()));
                xfers++;
                last_xfer_k = k;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (rd_en) begin
                check({tag, "_addr"}, 32'(ram_addr), 32'(issued));
                issued++;
                check({tag, "_outstanding_le2"}, 32'((issued - xfers) <= 2), 32'd1);
            end
            if (done) begin
                got_done = 1'b1;
                check({tag, "_done_after_xfers"}, 32'(xfers), 32'(len));
                check({tag, "_done_latency"}, 32'(k - last_xfer_k), 32'd1);
                check({tag, "_done_busy_excl"}, 32'(busy), 32'd0);
            end
            k++;
        end
        check({tag, "_done_seen"},     32'(got_done),      32'd1);
        check({tag, "_all_delivered"}, 32'(exp_q.size()),  32'd0);
        check({tag, "_reads_issued"},  32'(issued),        32'(len));
    endtask

    // ---------------- per-cycle vector table ----------------
    typedef struct {
        logic              start;
        logic [ADDR_W-1:0] length;
        logic              ready;
        logic              rd_en;
        logic [ADDR_W-1:0] addr;
        logic              valid;
        logic [DATA_W-1:0] data;
        logic              busy;
        logic              done;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int s, input int l, input int r, input int e_rd,
                           input int e_addr, input int e_valid, input int e_data,
                           input int e_busy, input int e_done);
        vec_t v;
        v.start  = 1'(s);
        v.length = ADDR_W'(l);
        v.ready  = 1'(r);
        v.rd_en  = 1'(e_rd);
        v.addr   = ADDR_W'(e_addr);
        v.valid  = 1'(e_valid);
        v.data   = DATA_W'(e_data);
        v.busy   = 1'(e_busy);
        v.done   = 1'(e_done);
        vecs.push_back(v);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        length    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_idle_outputs("reset");

`ifdef SAMPLE_FRAME_READER_LOOP_EN
        begin
            int  n = 0;
            bit  done_exp = 1'b0;
            for (int k = 0; k < 40; k++) begin
                next_cycle(k == 0, ADDR_W'(3), 1'b1);
                if (k > 0) check("loop_busy", 32'(busy), 32'd1);
                check("loop_done", 32'(done), 32'(done_exp));
                done_exp = 1'b0;
                if (out_valid && out_ready) begin
                    check("loop_data", 32'(out_data), 32'(100 + (n % 3)));
                    if ((n % 3) == 2) done_exp = 1'b1;
                    n++;
                end
            end
            check("loop_no_gap_count", 32'(n), 32'd38);
            @(negedge clk);
            reset = 1'b1;
            start = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            #1;
            check_idle_outputs("loop_stop");
        end
`else
        // Scenario A: LENGTH=4, OUT_READY=1
        add_vec(1, 4, 1,  0, 0, 0,   0, 0, 0);
        add_vec(0, 0, 1,  1, 0, 0,   0, 1, 0);
        add_vec(0, 0, 1,  1, 1, 1, 100, 1, 0);
        add_vec(0, 0, 1,  1, 2, 1, 101, 1, 0);
        add_vec(0, 0, 1,  1, 3, 1, 102, 1, 0);
        add_vec(0, 0, 1,  0, 0, 1, 103, 1, 0);
        add_vec(0, 0, 1,  0, 0, 0,   0, 0, 1);
        add_vec(0, 0, 1,  0, 0, 0,   0, 0, 0);
        // Scenario B: LENGTH=3, second START (LENGTH=4) while busy is ignored
        add_vec(1, 3, 1,  0, 0, 0,   0, 0, 0);
        add_vec(0, 0, 1,  1, 0, 0,   0, 1, 0);
        add_vec(1, 4, 1,  1, 1, 1, 100, 1, 0);
        add_vec(0, 0, 1,  1, 2, 1, 101, 1, 0);
        add_vec(0, 0, 1,  0, 0, 1, 102, 1, 0);
        add_vec(0, 0, 1,  0, 0, 0,   0, 0, 1);
        add_vec(0, 0, 1,  0, 0, 0,   0, 0, 0);
        add_vec(0, 0, 1,  0, 0, 0,   0, 0, 0);
        // Scenario C: LENGTH=0 -> DONE next cycle, no reads, never busy
        add_vec(1, 0, 1,  0, 0, 0,   0, 0, 0);
        add_vec(0, 0, 1,  0, 0, 0,   0, 0, 1);
        add_vec(0, 0, 1,  0, 0, 0,   0, 0, 0);
        // Scenario D: LENGTH=2 with stalls, skid buffer fills to two
        add_vec(1, 2, 0,  0, 0, 0,   0, 0, 0);
        add_vec(0, 0, 0,  1, 0, 0,   0, 1, 0);
        add_vec(0, 0, 0,  1, 1, 1, 100, 1, 0);
        add_vec(0, 0, 0,  0, 0, 1, 100, 1, 0);
        add_vec(0, 0, 1,  0, 0, 1, 100, 1, 0);
        add_vec(0, 0, 0,  0, 0, 1, 101, 1, 0);
        add_vec(0, 0, 1,  0, 0, 1, 101, 1, 0);
        add_vec(0, 0, 1,  0, 0, 0,   0, 0, 1);

        foreach (vecs[i]) begin
            next_cycle(vecs[i].start, vecs[i].length, vecs[i].ready);
            check($sformatf("vec%0d_rd_en", i), 32'(rd_en),     32'(vecs[i].rd_en));
            check($sformatf("vec%0d_addr",  i), 32'(ram_addr),  32'(vecs[i].addr));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d_data",  i), 32'(out_data),  32'(vecs[i].data));
            check($sformatf("vec%0d_busy",  i), 32'(busy),      32'(vecs[i].busy));
            check($sformatf("vec%0d_done",  i), 32'(done),      32'(vecs[i].done));
        end

        // LENGTH=8 with OUT_READY 1,0,0,1,0,0,...
        run_frame(8, 1, "len8_toggle");

        // Largest frame: addresses 0..1022, no wrap
        run_frame((1 << ADDR_W) - 1, 0, "len_max");

        // Reset after 3 of 8 samples, with a START in the reset cycle
        begin
            int k = 0;
            int xfers = 0;
            while (xfers < 3 && k < 30) begin
                next_cycle(k == 0, ADDR_W'(8), 1'b1);
                if (out_valid && out_ready) begin
                    check("rst_mid_data", 32'(out_data), 32'(100 + xfers));
                    xfers++;
                end
                k++;
            end
            check("rst_mid_reached", 32'(xfers), 32'd3);
            @(negedge clk);
            reset     = 1'b1;
            start     = 1'b1;
            length    = ADDR_W'(5);
            out_ready = 1'b0;
            @(negedge clk);
            reset  = 1'b0;
            start  = 1'b0;
            length = '0;
            #1;
            check_idle_outputs("rst_mid");
            next_cycle(1'b0, '0, 1'b1);
            check("rst_prio_busy",  32'(busy),      32'd0);
            check("rst_prio_rd_en", 32'(rd_en),     32'd0);
            check("rst_prio_valid", 32'(out_valid), 32'd0);
            run_frame(2, 0, "after_rst");
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary, got %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sample_frame_reader.md
SAMPLE_FRAME_READER -- requirements
Module: sample_frame_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 12, sample width in bits.
REQ-002 SHALL have parameter ADDR_W, default 10, sample RAM address width.
REQ-003 SHALL have port CLK  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port START  input  1  one-cycle frame start request.
REQ-006 SHALL have port LENGTH  input  ADDR_W  frame sample count; sampled when START is accepted.
REQ-007 SHALL have port RAM_RD_EN  output  1  sample RAM read strobe.
REQ-008 SHALL have port RAM_ADDR  output  ADDR_W  sample RAM read address.
REQ-009 SHALL have port RAM_DATA  input  DATA_W  RAM read data, valid exactly one cycle after RAM_RD_EN.
REQ-010 SHALL have port OUT_DATA  output  DATA_W  streamed sample.
REQ-011 SHALL have port OUT_VALID  output  1  OUT_DATA holds a sample.
REQ-012 SHALL have port OUT_READY  input  1  downstream accepts the sample.
REQ-013 SHALL have port BUSY  output  1  frame in progress.
REQ-014 SHALL have port DONE  output  1  one-cycle pulse after the last sample is accepted.

Function
REQ-015 SHALL implement states IDLE, READ, DRAIN; IDLE->READ on START with LENGTH!=0; READ->DRAIN after the last read is issued; DRAIN->IDLE once the last sample is transferred (OUT_VALID&&OUT_READY).
REQ-016 SHALL ignore START while BUSY=1.
REQ-017 SHALL, on START with LENGTH=0, remain IDLE and pulse DONE on the next cycle.
REQ-018 SHALL issue reads at addresses 0,1,...,LENGTH-1 in order, one per cycle at most.
REQ-019 SHALL issue the first read (RAM_RD_EN=1, RAM_ADDR=0) in the cycle after START is accepted; the first sample SHALL appear with OUT_VALID=1 one cycle later (START-to-OUT_VALID latency 2 cycles).
REQ-020 SHALL hold OUT_DATA stable and OUT_VALID high until OUT_READY=1; a transfer occurs on each cycle with OUT_VALID&&OUT_READY.
REQ-021 SHALL contain a 2-entry skid buffer and SHALL assert RAM_RD_EN only when (buffered samples + reads in flight) < 2 after the current cycle's transfer, so no RAM data is ever lost.
REQ-022 SHALL sustain 1 sample/cycle with OUT_READY held high.
REQ-023 SHALL deliver samples in address order with no duplication or omission under any OUT_READY pattern.
REQ-024 SHALL drive RAM_ADDR to 0 when RAM_RD_EN=0 and OUT_DATA to 0 when OUT_VALID=0.
REQ-025 SHALL treat LENGTH=2^ADDR_W-1 as the largest frame; the address counter SHALL NOT wrap within a frame.
REQ-026 SHALL hold BUSY=1 from the cycle after START acceptance until the cycle DONE pulses; DONE and BUSY SHALL NOT both be 1.

Reset
REQ-027 SHALL, on RESET=1 at a clock edge, enter IDLE, flush the skid buffer and discard in-flight reads, regardless of state.
REQ-028 SHALL drive after reset: RAM_RD_EN=0, RAM_ADDR=0, OUT_VALID=0, OUT_DATA=0, BUSY=0, DONE=0.
REQ-029 SHALL give RESET priority over START in the same cycle.

Configuration
REQ-030 SHALL, with macro SAMPLE_FRAME_READER_LOOP_EN defined, restart reading at address 0 after address LENGTH-1 with no gap, pulse DONE at each frame boundary, keep BUSY=1, and stop only on RESET.
REQ-031 SHALL, without SAMPLE_FRAME_READER_LOOP_EN, play each frame once and return to IDLE as in REQ-015.

Verification
REQ-032 SHALL cover: RAM[i]=i+100, START with LENGTH=4, OUT_READY=1 -> OUT_VALID at START+2, OUT_DATA 100,101,102,103 on consecutive cycles, DONE one cycle after the last transfer.
REQ-033 SHALL cover: LENGTH=8, OUT_READY toggling 1,0,0,1,... -> all 8 samples in order, no duplicates, RAM_RD_EN never exceeds 2 outstanding.
REQ-034 SHALL cover: START with LENGTH=0 -> DONE pulses next cycle, RAM_RD_EN stays 0, BUSY stays 0.
REQ-035 SHALL cover: RESET asserted mid-frame after 3 of 8 samples -> next cycle all outputs at reset values; new START with LENGTH=2 returns RAM[0],RAM[1].
REQ-036 SHALL cover: second START while BUSY with LENGTH=4 -> ignored, frame completes with original LENGTH.
REQ-037 SHALL cover: with SAMPLE_FRAME_READER_LOOP_EN, LENGTH=3, OUT_READY=1 -> OUT_DATA 100,101,102,100,101,102..., DONE every 3 transfers.
